// File: rtl/tbp_pkg.sv
// Shared definitions for the tournament branch predictor: predictor mode
// selectors, FSM state type and saturating counter helpers.
package tbp_pkg;

    localparam int MODE_GLOBAL = 0;
    localparam int MODE_LOCAL  = 1;
    localparam int MODE_TOURN  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tbp_state_t;

    // Counters are at most 4 bits wide; callers zero-extend into this width.
    function automatic logic [3:0] ctr_inc(input logic [3:0] v, input logic [3:0] vmax);
        return (v >= vmax) ? vmax : v + 4'd1;
    endfunction

    function automatic logic [3:0] ctr_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

endpackage

// File: rtl/tbp_table.sv
// Predictor table: one combinational read port, one read-modify-write
// update port (saturating counter or history shift), and an init-write
// port used by the power-up sweep. Contents are never reset directly.
module tbp_table
    import tbp_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DW    = 2,
    parameter bit SHIFT = 1'b0
) (
    input  logic          clk,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata,
    input  logic          i_upd,
    input  logic [AW-1:0] i_uaddr,
    input  logic          i_ubit,
    input  logic          i_init,
    input  logic [AW-1:0] i_init_addr,
    input  logic [DW-1:0] i_init_data
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] w_next;

    // Reads see pre-update contents when a same-cycle update hits the entry.
    assign o_rdata = r_mem[i_raddr];

    generate
        if (SHIFT) begin : g_shift
            assign w_next = {r_mem[i_uaddr][DW-2:0], i_ubit};
        end else begin : g_ctr
            localparam logic [3:0] CTR_MAX = 4'((1 << DW) - 1);
            logic [3:0] w_cur;
            assign w_cur  = 4'(r_mem[i_uaddr]);
            assign w_next = DW'(i_ubit ? ctr_inc(w_cur, CTR_MAX) : ctr_dec(w_cur));
        end
    endgenerate

    // Init sweep owns the write port while it runs; otherwise apply updates.
    always_ff @(posedge clk) begin
        if (i_init) begin
            r_mem[i_init_addr] <= i_init_data;
        end else if (i_upd) begin
            r_mem[i_uaddr] <= w_next;
        end
    end

endmodule

// File: rtl/tournament_bp.sv
// Tournament branch predictor: gshare-style global PHT, per-PC local
// history feeding a local PHT, and a chooser, with an init sweep after reset.
module tournament_bp
    import tbp_pkg::*;
#(
    parameter int PHT_DEPTH = 6,
    parameter int BHT_DEPTH = 6,
    parameter int CTR_W     = 2,
    parameter int MODE      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallD,
    input  logic                   flushD,
    input  logic [31:0]            pcF,
    input  logic                   branchF,
    input  logic                   branchD,
    output logic                   pred_takeD,
    output logic [2*PHT_DEPTH+1:0] pred_infoD,
    input  logic                   branchM,
    input  logic                   actual_takeM,
    input  logic                   pred_takeM,
    input  logic [31:0]            pcM,
    input  logic [2*PHT_DEPTH+1:0] pred_infoM,
    output logic                   ready,
    output logic [31:0]            branch_cnt,
    output logic [31:0]            mispred_cnt
);

    localparam int P  = PHT_DEPTH;
    localparam int B  = BHT_DEPTH;
    localparam int SW = (P > B) ? P : B;
    localparam bit USE_G = (MODE != MODE_LOCAL);
    localparam bit USE_L = (MODE != MODE_GLOBAL);
    localparam bit USE_C = (MODE == MODE_TOURN);
    localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

    tbp_state_t     r_state;
    logic [SW-1:0]  r_sweep;
    logic [P-1:0]   r_spec_ghr;
    logic [P-1:0]   r_ret_ghr;
    logic           r_final_d;
    logic [2*P+1:0] r_info_d;
    logic [31:0]    r_branch_cnt;
    logic [31:0]    r_mispred_cnt;

    logic           w_init, w_ready, w_upd, w_mispred, w_unused;
    logic [P-1:0]   w_cidx_f, w_gidx_f, w_lidx_f, w_bht_f;
    logic [B-1:0]   w_bidx_f, w_bidx_m;
    logic [CTR_W-1:0] w_gctr_f, w_lctr_f, w_cctr_f;
    logic           w_gpred_f, w_lpred_f, w_final_f;
    logic [2*P+1:0] w_info_f;
    logic [P-1:0]   w_gidx_m, w_lidx_m, w_cidx_m;
    logic           w_gpred_m, w_lpred_m;

    assign w_init    = (r_state == ST_INIT);
    assign w_ready   = (r_state == ST_RUN);
    assign w_upd     = branchM & w_ready;
    assign w_mispred = branchM & (actual_takeM != pred_takeM);
    assign w_unused  = ^{pcF, pcM};

    assign w_cidx_f  = pcF[P+1:2];
    assign w_bidx_f  = pcF[B+1:2];
    assign w_cidx_m  = pcM[P+1:2];
    assign w_bidx_m  = pcM[B+1:2];
    assign w_gidx_m  = pred_infoM[2*P+1:P+2];
    assign w_lidx_m  = pred_infoM[P+1:2];
    assign w_gpred_m = pred_infoM[1];
    assign w_lpred_m = pred_infoM[0];

    generate
        if (USE_G) begin : g_global
            assign w_gidx_f = w_cidx_f ^ r_spec_ghr;
            tbp_table #(.AW(P), .DW(CTR_W), .SHIFT(1'b0)) u_gpht (
                .clk(clk), .i_raddr(w_gidx_f), .o_rdata(w_gctr_f),
                .i_upd(w_upd), .i_uaddr(w_gidx_m), .i_ubit(actual_takeM),
                .i_init(w_init), .i_init_addr(r_sweep[P-1:0]), .i_init_data(CTR_WEAK)
            );
        end else begin : g_no_global
            assign w_gidx_f = '0;
            assign w_gctr_f = '0;
        end

        if (USE_L) begin : g_local
            tbp_table #(.AW(B), .DW(P), .SHIFT(1'b1)) u_bht (
                .clk(clk), .i_raddr(w_bidx_f), .o_rdata(w_bht_f),
                .i_upd(w_upd), .i_uaddr(w_bidx_m), .i_ubit(actual_takeM),
                .i_init(w_init), .i_init_addr(r_sweep[B-1:0]), .i_init_data('0)
            );
            assign w_lidx_f = w_cidx_f ^ w_bht_f;
            tbp_table #(.AW(P), .DW(CTR_W), .SHIFT(1'b0)) u_lpht (
                .clk(clk), .i_raddr(w_lidx_f), .o_rdata(w_lctr_f),
                .i_upd(w_upd), .i_uaddr(w_lidx_m), .i_ubit(actual_takeM),
                .i_init(w_init), .i_init_addr(r_sweep[P-1:0]), .i_init_data(CTR_WEAK)
            );
        end else begin : g_no_local
            assign w_bht_f  = '0;
            assign w_lidx_f = '0;
            assign w_lctr_f = '0;
        end

        if (USE_C) begin : g_chooser
            // Chooser only learns when the two components disagreed.
            tbp_table #(.AW(P), .DW(CTR_W), .SHIFT(1'b0)) u_chooser (
                .clk(clk), .i_raddr(w_cidx_f), .o_rdata(w_cctr_f),
                .i_upd(w_upd & (w_gpred_m != w_lpred_m)), .i_uaddr(w_cidx_m),
                .i_ubit(w_gpred_m == actual_takeM),
                .i_init(w_init), .i_init_addr(r_sweep[P-1:0]), .i_init_data(CTR_WEAK)
            );
        end else begin : g_no_chooser
            assign w_cctr_f = '0;
        end
    endgenerate

    assign w_gpred_f = w_gctr_f[CTR_W-1];
    assign w_lpred_f = w_lctr_f[CTR_W-1];
    assign w_info_f  = {w_gidx_f, w_lidx_f, w_gpred_f, w_lpred_f};

    // Select the final fetch-stage prediction according to MODE.
    always_comb begin
        w_final_f = 1'b0;
        case (MODE)
            MODE_GLOBAL: w_final_f = w_gpred_f;
            MODE_LOCAL:  w_final_f = w_lpred_f;
            default:     w_final_f = w_cctr_f[CTR_W-1] ? w_gpred_f : w_lpred_f;
        endcase
    end

    // Init sweep walks every table index once, then hands over to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweep <= r_sweep + 1'b1;
            if (r_sweep == '1) begin
                r_state <= ST_RUN;
            end
        end
    end

    // F->D pipeline register; flush wins over stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_final_d <= 1'b0;
            r_info_d  <= '0;
        end else if (flushD) begin
            r_final_d <= 1'b0;
            r_info_d  <= '0;
        end else if (!stallD) begin
            r_final_d <= w_final_f;
            r_info_d  <= w_info_f;
        end
    end

    // Speculative and retired global history; a mispredict repairs the
    // speculative copy from the retired one, overriding any fetch shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spec_ghr <= '0;
            r_ret_ghr  <= '0;
        end else if (w_ready) begin
            if (branchM) begin
                r_ret_ghr <= {r_ret_ghr[P-2:0], actual_takeM};
            end
            if (w_mispred) begin
                r_spec_ghr <= {r_ret_ghr[P-2:0], actual_takeM};
            end else if (branchF && !stallD) begin
                r_spec_ghr <= {r_spec_ghr[P-2:0], w_final_f};
            end
        end
    end

    // Saturating performance counters for resolved branches and mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_ready) begin
            if (branchM && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign ready       = w_ready;
    assign pred_takeD  = branchD & w_ready & r_final_d;
    assign pred_infoD  = r_info_d;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_tournament_bp.sv
// Directed bench for tournament_bp: a behavioural reference model of the
// tournament predictor feeds a scoreboard of expected D-stage predictions.
module tb_tournament_bp;

    logic        clk;
    logic        rst;
    logic        stallD, flushD, branchF, branchD;
    logic [31:0] pcF, pcM;
    logic        branchM, actual_takeM, pred_takeM, pred_takeM_l;
    logic [13:0] pred_infoM, pred_infoM_l;

    logic        pred_takeD, ready;
    logic [13:0] pred_infoD;
    logic [31:0] branch_cnt, mispred_cnt;
    logic        pred_takeD_l, ready_l;
    logic [13:0] pred_infoD_l;
    logic [31:0] branch_cnt_l, mispred_cnt_l;

    tournament_bp #(.PHT_DEPTH(6), .BHT_DEPTH(6), .CTR_W(2), .MODE(2)) dut (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
        .pcF(pcF), .branchF(branchF), .branchD(branchD),
        .pred_takeD(pred_takeD), .pred_infoD(pred_infoD),
        .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
        .pcM(pcM), .pred_infoM(pred_infoM),
        .ready(ready), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    tournament_bp #(.PHT_DEPTH(6), .BHT_DEPTH(6), .CTR_W(2), .MODE(1)) dut_l (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
        .pcF(pcF), .branchF(branchF), .branchD(branchD),
        .pred_takeD(pred_takeD_l), .pred_infoD(pred_infoD_l),
        .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeM(pred_takeM_l),
        .pcM(pcM), .pred_infoM(pred_infoM_l),
        .ready(ready_l), .branch_cnt(branch_cnt_l), .mispred_cnt(mispred_cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (MODE 2, 6-bit indices, 2-bit counters)
    typedef struct {
        logic        take;
        logic [13:0] info;
    } exp_t;

    exp_t        sb[$];
    int unsigned m_gp[64];
    int unsigned m_lp[64];
    int unsigned m_ch[64];
    logic [5:0]  m_bh[64];
    logic [5:0]  m_sghr, m_rghr;
    int unsigned m_bcnt, m_mcnt;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_gp[i] = 2; m_lp[i] = 2; m_ch[i] = 2; m_bh[i] = '0;
        end
        m_sghr = '0; m_rghr = '0; m_bcnt = 0; m_mcnt = 0;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input logic up);
        if (up) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic void model_fetch(input logic [31:0] pc, output exp_t e);
        logic [5:0] ci, gi, li;
        logic gp, lp;
        ci = pc[7:2];
        gi = ci ^ m_sghr;
        li = ci ^ m_bh[ci];
        gp = (m_gp[gi] >= 2);
        lp = (m_lp[li] >= 2);
        e.take = (m_ch[ci] >= 2) ? gp : lp;
        e.info = {gi, li, gp, lp};
        m_sghr = {m_sghr[4:0], e.take};
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [13:0] info,
                                         input logic act, input logic ptk);
        logic [5:0] ci, gi, li;
        logic gp, lp;
        ci = pc[7:2];
        gi = info[13:8];
        li = info[7:2];
        gp = info[1];
        lp = info[0];
        m_gp[gi] = sat(m_gp[gi], act);
        m_lp[li] = sat(m_lp[li], act);
        if (gp != lp) m_ch[ci] = sat(m_ch[ci], gp == act);
        m_bh[ci] = {m_bh[ci][4:0], act};
        m_rghr = {m_rghr[4:0], act};
        m_bcnt++;
        if (act != ptk) begin
            m_mcnt++;
            m_sghr = m_rghr;
        end
    endfunction

    // One branch walked through F, D and M with no overlap.
    task automatic run_branch(input logic [31:0] pc, input logic act, input bit chk_l,
                              output logic got);
        exp_t e;
        logic tk_l;
        logic [13:0] inf_l;
        @(negedge clk);
        pcF = pc; branchF = 1'b1;
        model_fetch(pc, e);
        sb.push_back(e);
        @(negedge clk);
        branchF = 1'b0; branchD = 1'b1;
        #1;
        e = sb.pop_front();
        check("pred_takeD", 32'(pred_takeD), 32'(e.take));
        check("pred_infoD", 32'(pred_infoD), 32'(e.info));
        got = pred_takeD;
        if (chk_l) check("local_pred", 32'(pred_takeD_l), 32'(act));
        tk_l = pred_takeD_l;
        inf_l = pred_infoD_l;
        @(negedge clk);
        branchD = 1'b0; branchM = 1'b1; pcM = pc; actual_takeM = act;
        pred_takeM = e.take; pred_infoM = e.info;
        pred_takeM_l = tk_l; pred_infoM_l = inf_l;
        model_update(pc, e.info, act, e.take);
        @(negedge clk);
        branchM = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int unsigned cyc;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!ready) check({tag, "_predD_init"}, 32'(pred_takeD), 32'd0);
        end
        check({tag, "_ready_cycles"}, cyc, 32'd64);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        logic [5:0] pat;
        exp_t e, e2;
        int unsigned ml16;

        rst = 1'b1; stallD = 0; flushD = 0; pcF = '0; branchF = 0; branchD = 0;
        branchM = 0; actual_takeM = 0; pred_takeM = 0; pcM = '0; pred_infoM = '0;
        pred_takeM_l = 0; pred_infoM_l = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_bcnt", branch_cnt, 32'd0);
        check("rst_mcnt", mispred_cnt, 32'd0);
        check("rst_infoD", 32'(pred_infoD), 32'd0);

        // Init sweep: ready after 64 cycles, no prediction even with branchD
        branchD = 1'b1;
        rst = 1'b0;
        wait_ready("init");
        check("init_ready_l", 32'(ready_l), 32'd1);
        branchD = 1'b0;

        // Always-taken branch at 0x100
        for (int i = 0; i < 20; i++) begin
            run_branch(32'h100, 1'b1, 1'b0, got);
            if (i == 0) check("first_pred_taken", 32'(got), 32'd1);
        end
        check("taken_bcnt", branch_cnt, 32'd20);
        check("taken_mcnt", mispred_cnt, 32'd0);

        // Alternating T,N at 0x200; local-only instance must settle by 16
        ml16 = 0;
        for (int i = 1; i <= 40; i++) begin
            run_branch(32'h200, (i % 2) == 1, i > 16, got);
            if (i == 16) ml16 = mispred_cnt_l;
        end
        check("alt_local_mcnt_stable", mispred_cnt_l, ml16);
        check("alt_bcnt", branch_cnt, m_bcnt);
        check("alt_mcnt", mispred_cnt, m_mcnt);

        // Flush and stall together: flush wins
        @(negedge clk);
        pcF = 32'h100; stallD = 1'b0; flushD = 1'b0; branchF = 1'b0;
        @(negedge clk);
        flushD = 1'b1; stallD = 1'b1; branchD = 1'b1;
        @(negedge clk);
        #1;
        check("flush_predD", 32'(pred_takeD), 32'd0);
        check("flush_infoD", 32'(pred_infoD), 32'd0);
        flushD = 1'b0; stallD = 1'b0; branchD = 1'b0;

        // Shape retired history to 101100, then mispredict with concurrent fetch
        pat = 6'b101100;
        for (int i = 5; i >= 0; i--) run_branch(32'h300, pat[i], 1'b0, got);
        check("ret_ghr_shaped", 32'(dut.r_ret_ghr), 32'(6'b101100));
        @(negedge clk);
        pcF = 32'h300; branchF = 1'b1;
        model_fetch(32'h300, e);
        @(negedge clk);
        branchF = 1'b0;
        @(negedge clk);
        branchM = 1'b1; pcM = 32'h300; actual_takeM = 1'b1; pred_takeM = 1'b0;
        pred_infoM = e.info; pred_takeM_l = 1'b0; pred_infoM_l = '0;
        branchF = 1'b1; pcF = 32'h100;
        model_fetch(32'h100, e2);
        model_update(32'h300, e.info, 1'b1, 1'b0);
        @(negedge clk);
        branchM = 1'b0; branchF = 1'b0;
        check("spec_ghr_restore", 32'(dut.r_spec_ghr), 32'(6'b011001));
        check("spec_ghr_model", 32'(dut.r_spec_ghr), 32'(m_sghr));
        check("misp_bcnt", branch_cnt, m_bcnt);
        check("misp_mcnt", mispred_cnt, m_mcnt);

        // Asynchronous reset clears state immediately, then mid-sweep restart
        @(posedge clk);
        #2;
        branchD = 1'b1;
        rst = 1'b1;
        #1;
        check("async_bcnt", branch_cnt, 32'd0);
        check("async_mcnt", mispred_cnt, 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_infoD", 32'(pred_infoD), 32'd0);
        check("async_predD", 32'(pred_takeD), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("sweep_at_30", 32'(dut.r_sweep), 32'd30);
        rst = 1'b1;
        #1;
        check("sweep_cleared", 32'(dut.r_sweep), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("restart");
        branchD = 1'b0;
        check("restart_bcnt", branch_cnt, 32'd0);

        // Tables reinitialised by the restarted sweep
        model_reset();
        for (int i = 0; i < 3; i++) run_branch(32'h100, 1'b1, 1'b0, got);
        check("post_bcnt", branch_cnt, 32'd3);
        check("post_mcnt", mispred_cnt, m_mcnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tournament_bp.md
TOURNAMENT_BP -- requirements
Module: tournament_bp

Interface
REQ-001 Parameters (name, default, meaning): PHT_DEPTH, 6, log2 entries of global PHT, local PHT and chooser; also the GHR/BHR length.
REQ-002 BHT_DEPTH, 6, log2 entries of the local history table.
REQ-003 CTR_W, 2, width of every saturating counter (range 2..4).
REQ-004 MODE, 2, predictor selection: 0 global only, 1 local only, 2 tournament.
REQ-005 Ports (name, direction, width, meaning): clk, in, 1, single clock; rst, in, 1, reset, asynchronous, active-high.
REQ-006 stallD, in, 1: hold F->D register. flushD, in, 1: clear F->D register.
REQ-007 pcF, in, 32: fetch PC. branchF, in, 1: fetch instruction is a branch.
REQ-008 branchD, in, 1: decode instruction is a branch. pred_takeD, out, 1: final prediction.
REQ-009 pred_infoD, out, 2*PHT_DEPTH+2: {gidx, lidx, gpred, lpred}, carried by the pipeline to M.
REQ-010 branchM, actual_takeM, pred_takeM, in, 1 each: resolved branch, its outcome, and the prediction used for it. pcM, in, 32. pred_infoM, in, 2*PHT_DEPTH+2.
REQ-011 ready, out, 1: tables initialised. branch_cnt, out, 32 and mispred_cnt, out, 32: performance counters.

Function
REQ-012 FSM states are INIT and RUN; reset enters INIT.
REQ-013 INIT: a sweep counter walks 0 to 2^max(PHT_DEPTH,BHT_DEPTH)-1, one entry per cycle. Each cycle it writes: PHTs to 2^(CTR_W-1) (weakly taken); chooser to 2^(CTR_W-1) (weakly global); BHT to 0.
REQ-014 On the last sweep index the FSM moves to RUN; ready=1 from the next cycle.
REQ-015 While ready=0, pred_takeD=0, GHR is frozen, and all M-stage updates and counter increments are ignored.
REQ-016 Index functions: gidx = pcF[PHT_DEPTH+1:2] ^ specGHR; lidx = pcF[PHT_DEPTH+1:2] ^ BHT[pcF[BHT_DEPTH+1:2]]; chooser index = pcF[PHT_DEPTH+1:2].
REQ-017 Component predictions: a counter predicts taken iff its MSB=1. Chooser MSB=1 selects global.
REQ-018 finalF = global (MODE 0), local (MODE 1), or chooser-selected (MODE 2).
REQ-019 All F-stage reads are combinational and return pre-update contents when a same-cycle M write hits the same entry.
REQ-020 F->D register holds finalF and infoF. It loads when ~stallD and clears to 0 on flushD; flush has priority over stall.
REQ-021 pred_takeD = branchD & ready & finalF_r. pred_infoD = infoF_r.
REQ-022 Speculative GHR: shifts left, inserting finalF, when branchF & ~stallD & ready.
REQ-023 Retired GHR: shifts left, inserting actual_takeM, on branchM.
REQ-024 Mispredict = branchM & (actual_takeM != pred_takeM). On a mispredict, specGHR <= {retiredGHR[PHT_DEPTH-2:0], actual_takeM}, overriding any same-cycle F shift.
REQ-025 M-stage updates on branchM use indices from pred_infoM, not recomputed ones.
REQ-026 Global PHT[gidx] and local PHT[lidx] each count +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1.
REQ-027 BHT[pcM[BHT_DEPTH+1:2]] shifts in actual_takeM.
REQ-028 Chooser updates only if gpred != lpred: +1 if gpred was correct, -1 otherwise, saturating.
REQ-029 In MODE 0/1 the unused tables need not be implemented; pred_infoD fields for them read 0.
REQ-030 branch_cnt increments on branchM; mispred_cnt increments on mispredict. Both saturate at 0xFFFFFFFF.

Reset
REQ-031 Asserting rst, at any time including mid-sweep, immediately sets: FSM=INIT, sweep counter=0, ready=0, specGHR=retiredGHR=0, F->D register=0, pred_takeD=0, pred_infoD=0, both perf counters=0.
REQ-032 Table arrays are not reset directly; only the INIT sweep initialises them.

Structure
REQ-033 Package tbp_pkg holds: MODE constants (MODE_GLOBAL, MODE_LOCAL, MODE_TOURN), the FSM state enum, and the counter saturate-increment/decrement functions.
REQ-034 Sub-module tbp_table is a parametrised 1-read/1-write array with an init-write port. It is instantiated for the global PHT, local PHT, chooser and BHT.

Verification
REQ-035 Release rst -> ready rises after exactly 64 cycles (defaults); pred_takeD=0 throughout, even with branchD=1.
REQ-036 Branch at pc 0x100 always taken, 20 iterations -> pred_takeD=1 on the first; mispred_cnt=0; branch_cnt=20.
REQ-037 Pattern T,N,T,N at pc 0x200, MODE 1, 40 iterations -> no mispredicts after iteration 16.
REQ-038 Mispredict at M with retiredGHR=6'b101100, actual=1, concurrent branchF -> specGHR=6'b011001 next cycle.
REQ-039 flushD and stallD asserted together with branchD=1 -> pred_takeD=0 and pred_infoD=0 next cycle.
REQ-040 rst pulse at sweep index 30 -> sweep restarts at 0; ready rises 64 cycles after release; prior counts cleared.
